// File: rtl/ternary_to_binary_decoder.sv
// ---------------------------------------------------------------------------
// ternary_to_binary_decoder
//
// Converts one balanced-ternary word into a signed two's-complement integer.
// Trits are consumed one per clock, most significant first, using Horner
// evaluation (acc = 3*acc + trit).
//
// Trit encoding: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1, 2'b10 = illegal.
// An illegal trit contributes 0 and flags err for that word.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   input word presented
//   in_ready   block is idle and can accept a word
//   in_word    ternary word; trit i in bits [2i+1:2i], trit WORD_SIZE-1 is MSB
//   out_valid  result available (held until out_ready)
//   out_ready  consumer accepts the result
//   bin_out    signed two's-complement value of the last word
//   err        last word contained at least one illegal trit
//   is_zero    bin_out == 0 (qualified by out_valid)
//
// Sizing rule: 2^(BIN_WIDTH-1) > (3^WORD_SIZE-1)/2. If violated, the result
// wraps modulo 2^BIN_WIDTH without any flag.
// ---------------------------------------------------------------------------
module ternary_to_binary_decoder #(
  parameter int WORD_SIZE = 9,
  parameter int BIN_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*WORD_SIZE-1:0] in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_WIDTH-1:0]   bin_out,
  output logic                   err,
  output logic                   is_zero
);

  // Counter is at least one bit wide so WORD_SIZE = 1 still elaborates.
  localparam int CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state_reg;
  state_t                       state_next;

  logic [2*WORD_SIZE-1:0]       word_reg;
  logic signed [BIN_WIDTH-1:0]  acc_reg;
  logic                         err_acc_reg;
  logic [CNT_W-1:0]             cnt_reg;
  logic [BIN_WIDTH-1:0]         bin_out_reg;
  logic                         err_reg;
  logic                         is_zero_reg;

  // Per-trit decode of the captured word.
  logic [WORD_SIZE-1:0]         trit_neg;
  logic [WORD_SIZE-1:0]         trit_pos;
  logic [WORD_SIZE-1:0]         trit_ill;

  generate
    for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_trit
      assign trit_neg[gi] = (word_reg[2*gi+1 -: 2] == 2'b11);
      assign trit_pos[gi] = (word_reg[2*gi+1 -: 2] == 2'b01);
      assign trit_ill[gi] = (word_reg[2*gi+1 -: 2] == 2'b10);
    end
  endgenerate

  // Select the trit currently pointed to by the counter.
  logic cur_neg;
  logic cur_pos;
  logic cur_ill;

  always_comb begin
    cur_neg = 1'b0;
    cur_pos = 1'b0;
    cur_ill = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        cur_neg = trit_neg[i];
        cur_pos = trit_pos[i];
        cur_ill = trit_ill[i];
      end
    end
  end

  // Horner step: 3*acc is formed as (acc << 1) + acc; illegal trits add 0.
  logic signed [BIN_WIDTH-1:0] trit_ext;
  logic signed [BIN_WIDTH-1:0] sum_next;
  logic                        err_next;

  always_comb begin
    trit_ext = '0;
    if (cur_neg) begin
      trit_ext = '1;
    end else if (cur_pos) begin
      trit_ext = BIN_WIDTH'(1);
    end
    sum_next = (acc_reg <<< 1) + acc_reg + trit_ext;
    err_next = err_acc_reg | cur_ill;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)          state_next = CONV;
      CONV:    if (cnt_reg == '0)     state_next = DONE;
      DONE:    if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_reg    <= '0;
      acc_reg     <= '0;
      err_acc_reg <= 1'b0;
      cnt_reg     <= '0;
      bin_out_reg <= '0;
      err_reg     <= 1'b0;
      is_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            word_reg    <= in_word;
            acc_reg     <= '0;
            err_acc_reg <= 1'b0;
            cnt_reg     <= CNT_W'(WORD_SIZE - 1);
          end
        end
        CONV: begin
          acc_reg     <= sum_next;
          err_acc_reg <= err_next;
          if (cnt_reg == '0) begin
            bin_out_reg <= sum_next;
            err_reg     <= err_next;
            is_zero_reg <= (sum_next == '0);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          // DONE: result registers hold their value.
        end
      endcase
    end
  end

  assign bin_out = bin_out_reg;
  assign err     = err_reg;
  assign is_zero = is_zero_reg;

endmodule
